// File: rtl/sid_pkg.sv
// Shared register map and bit-position constants for the SID register-write front end.
package sid_pkg;

    typedef enum logic [2:0] {
        REG_FREQ_LO = 3'd0,
        REG_FREQ_HI = 3'd1,
        REG_PW_LO   = 3'd2,
        REG_PW_HI   = 3'd3,
        REG_ATK     = 3'd4,
        REG_SUS     = 3'd5,
        REG_WAV     = 3'd6
    } voice_reg_e;

    typedef enum logic [2:0] {
        REG_FC_LO    = 3'd0,
        REG_FC_HI    = 3'd1,
        REG_RES_FILT = 3'd2,
        REG_MODE_VOL = 3'd3
    } filt_reg_e;

    localparam logic [1:0] VOICE_FILT = 2'd3;

    localparam int unsigned WAV_GATE  = 0;
    localparam int unsigned WAV_TRI   = 4;
    localparam int unsigned WAV_SAW   = 5;
    localparam int unsigned WAV_PULSE = 6;
    localparam int unsigned WAV_NOISE = 7;

    localparam int unsigned MODE_LP = 4;
    localparam int unsigned MODE_BP = 5;
    localparam int unsigned MODE_HP = 6;

endpackage

// File: rtl/sid_reg_if_if.sv
// Pin-level register write bus: strobe, voice select, address and data.
interface sid_wr_bus;
    logic       wr_strobe;
    logic [1:0] voice_sel;
    logic [2:0] addr;
    logic [7:0] wr_data;

    modport master (output wr_strobe, output voice_sel, output addr, output wr_data);
    modport slave  (input  wr_strobe, input  voice_sel, input  addr, input  wr_data);
endinterface

// File: rtl/sid_reg_if_strobe_sync.sv
// Multi-stage synchronizer for the asynchronous write strobe plus rising-edge detect.
module sid_strobe_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_async,
    output logic strobe_rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Flops reset high so a strobe already high at reset release is not seen as an edge.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], strobe_async};
        hist_d      = sync_q[SYNC_STAGES-1];
        strobe_rise = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

endmodule

// File: rtl/sid_reg_if.sv
// SID register-write front end: decodes synchronized strobe writes into the
// per-voice and filter register file and generates gate-edge pulses.
module sid_reg_if
    import sid_pkg::*;
#(
    parameter int unsigned NUM_VOICES  = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    sid_wr_bus.slave                  wr,
    output logic [16*NUM_VOICES-1:0]  freq,
    output logic [12*NUM_VOICES-1:0]  pw,
    output logic [8*NUM_VOICES-1:0]   atk_dcy,
    output logic [8*NUM_VOICES-1:0]   sus_rel,
    output logic [8*NUM_VOICES-1:0]   wav_ctrl,
    output logic [10:0]               fc,
    output logic [7:0]                res_filt,
    output logic [7:0]                mode_vol,
    output logic [NUM_VOICES-1:0]     gate_on,
    output logic [NUM_VOICES-1:0]     gate_off,
    output logic                      wr_ack
);

    logic strobe_rise;
    logic commit;

    logic [7:0] freq_lo_q [NUM_VOICES];
    logic [7:0] freq_lo_d [NUM_VOICES];
    logic [7:0] freq_hi_q [NUM_VOICES];
    logic [7:0] freq_hi_d [NUM_VOICES];
    logic [7:0] pw_lo_q   [NUM_VOICES];
    logic [7:0] pw_lo_d   [NUM_VOICES];
    logic [3:0] pw_hi_q   [NUM_VOICES];
    logic [3:0] pw_hi_d   [NUM_VOICES];
    logic [7:0] atk_q     [NUM_VOICES];
    logic [7:0] atk_d     [NUM_VOICES];
    logic [7:0] sus_q     [NUM_VOICES];
    logic [7:0] sus_d     [NUM_VOICES];
    logic [7:0] wav_q     [NUM_VOICES];
    logic [7:0] wav_d     [NUM_VOICES];

    logic [2:0] fc_lo_q, fc_lo_d;
    logic [7:0] fc_hi_q, fc_hi_d;
    logic [7:0] res_filt_q, res_filt_d;
    logic [7:0] mode_vol_q, mode_vol_d;

    logic [NUM_VOICES-1:0] gate_prev_q, gate_prev_d;
    logic [NUM_VOICES-1:0] gate_on_q, gate_on_d;
    logic [NUM_VOICES-1:0] gate_off_q, gate_off_d;
    logic                  wr_ack_q, wr_ack_d;

    sid_strobe_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .clk          (clk),
        .rst_n        (rst_n),
        .strobe_async (wr.wr_strobe),
        .strobe_rise  (strobe_rise)
    );

    // The edge is consumed whether or not ena is high; a disabled write is simply lost.
    assign commit = strobe_rise & ena;

    always_comb begin
        freq_lo_d  = freq_lo_q;
        freq_hi_d  = freq_hi_q;
        pw_lo_d    = pw_lo_q;
        pw_hi_d    = pw_hi_q;
        atk_d      = atk_q;
        sus_d      = sus_q;
        wav_d      = wav_q;
        fc_lo_d    = fc_lo_q;
        fc_hi_d    = fc_hi_q;
        res_filt_d = res_filt_q;
        mode_vol_d = mode_vol_q;
        wr_ack_d   = 1'b0;

        if (commit) begin
            wr_ack_d = 1'b1;
            if (wr.voice_sel == VOICE_FILT) begin
                case (filt_reg_e'(wr.addr))
                    REG_FC_LO:    fc_lo_d    = wr.wr_data[2:0];
                    REG_FC_HI:    fc_hi_d    = wr.wr_data;
                    REG_RES_FILT: res_filt_d = wr.wr_data;
                    REG_MODE_VOL: mode_vol_d = wr.wr_data;
                    default: ;
                endcase
            end else begin
                for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                    if (32'(wr.voice_sel) == v) begin
                        case (voice_reg_e'(wr.addr))
                            REG_FREQ_LO: freq_lo_d[v] = wr.wr_data;
                            REG_FREQ_HI: freq_hi_d[v] = wr.wr_data;
                            REG_PW_LO:   pw_lo_d[v]   = wr.wr_data;
                            REG_PW_HI:   pw_hi_d[v]   = wr.wr_data[3:0];
                            REG_ATK:     atk_d[v]     = wr.wr_data;
                            REG_SUS:     sus_d[v]     = wr.wr_data;
                            REG_WAV:     wav_d[v]     = wr.wr_data;
                            default: ;
                        endcase
                    end
                end
            end
        end

        // Gate edges are taken from the stored WAV register, so pulses land one cycle after commit.
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            gate_prev_d[v] = wav_q[v][WAV_GATE];
            gate_on_d[v]   = wav_q[v][WAV_GATE] & ~gate_prev_q[v];
            gate_off_d[v]  = ~wav_q[v][WAV_GATE] & gate_prev_q[v];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freq_lo_q   <= '{default: '0};
            freq_hi_q   <= '{default: '0};
            pw_lo_q     <= '{default: '0};
            pw_hi_q     <= '{default: '0};
            atk_q       <= '{default: '0};
            sus_q       <= '{default: '0};
            wav_q       <= '{default: '0};
            fc_lo_q     <= '0;
            fc_hi_q     <= '0;
            res_filt_q  <= '0;
            mode_vol_q  <= '0;
            gate_prev_q <= '0;
            gate_on_q   <= '0;
            gate_off_q  <= '0;
            wr_ack_q    <= 1'b0;
        end else begin
            freq_lo_q   <= freq_lo_d;
            freq_hi_q   <= freq_hi_d;
            pw_lo_q     <= pw_lo_d;
            pw_hi_q     <= pw_hi_d;
            atk_q       <= atk_d;
            sus_q       <= sus_d;
            wav_q       <= wav_d;
            fc_lo_q     <= fc_lo_d;
            fc_hi_q     <= fc_hi_d;
            res_filt_q  <= res_filt_d;
            mode_vol_q  <= mode_vol_d;
            gate_prev_q <= gate_prev_d;
            gate_on_q   <= gate_on_d;
            gate_off_q  <= gate_off_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    always_comb begin
        freq     = '0;
        pw       = '0;
        atk_dcy  = '0;
        sus_rel  = '0;
        wav_ctrl = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            freq[16*v +: 16]    = {freq_hi_q[v], freq_lo_q[v]};
            pw[12*v +: 12]      = {pw_hi_q[v], pw_lo_q[v]};
            atk_dcy[8*v +: 8]   = atk_q[v];
            sus_rel[8*v +: 8]   = sus_q[v];
            wav_ctrl[8*v +: 8]  = wav_q[v];
        end
    end

    assign fc       = {fc_hi_q, fc_lo_q};
    assign res_filt = res_filt_q;
    assign mode_vol = mode_vol_q;
    assign gate_on  = gate_on_q;
    assign gate_off = gate_off_q;
    assign wr_ack   = wr_ack_q;

endmodule

// File: tb/tb_sid_reg_if.sv
// Directed bench for sid_reg_if: hand-computed register map, timing and gate-pulse checks.
module tb_sid_reg_if;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [47:0] freq;
    logic [35:0] pw;
    logic [23:0] atk_dcy;
    logic [23:0] sus_rel;
    logic [23:0] wav_ctrl;
    logic [10:0] fc;
    logic [7:0]  res_filt;
    logic [7:0]  mode_vol;
    logic [2:0]  gate_on;
    logic [2:0]  gate_off;
    logic        wr_ack;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int gon2_cnt = 0;
    int goff2_cnt = 0;
    int base_ack, base_gon, base_goff;

    sid_wr_bus wr_bus ();

    sid_reg_if #(
        .NUM_VOICES  (3),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .wr       (wr_bus),
        .freq     (freq),
        .pw       (pw),
        .atk_dcy  (atk_dcy),
        .sus_rel  (sus_rel),
        .wav_ctrl (wav_ctrl),
        .fc       (fc),
        .res_filt (res_filt),
        .mode_vol (mode_vol),
        .gate_on  (gate_on),
        .gate_off (gate_off),
        .wr_ack   (wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_ack)      ack_cnt++;
            if (gate_on[2])  gon2_cnt++;
            if (gate_off[2]) goff2_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One write with a 1-high / 2-low strobe; returns just after the commit edge.
    task automatic write_reg(input logic [1:0] vs, input logic [2:0] a, input logic [7:0] d);
        wr_bus.voice_sel = vs;
        wr_bus.addr      = a;
        wr_bus.wr_data   = d;
        wr_bus.wr_strobe = 1'b1;
        tick();
        wr_bus.wr_strobe = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        rst_n            = 1'b0;
        ena              = 1'b1;
        wr_bus.wr_strobe = 1'b0;
        wr_bus.voice_sel = 2'd0;
        wr_bus.addr      = 3'd0;
        wr_bus.wr_data   = 8'd0;
        tick();
        tick();
        check("rst_freq", 48'(freq), 48'h0);
        check("rst_pw_wav", 48'({pw, wav_ctrl}), 48'h0);
        check("rst_env", 48'({atk_dcy, sus_rel}), 48'h0);
        check("rst_filt", 48'({fc, res_filt, mode_vol}), 48'h0);
        check("rst_pulses", 48'({gate_on, gate_off, wr_ack}), 48'h0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("no_write_after_rst", 48'(ack_cnt), 48'd0);

        // Voice 0 FREQ_LO with explicit latency checks.
        base_ack = ack_cnt;
        wr_bus.voice_sel = 2'd0;
        wr_bus.addr      = 3'd0;
        wr_bus.wr_data   = 8'h24;
        wr_bus.wr_strobe = 1'b1;
        tick();
        wr_bus.wr_strobe = 1'b0;
        tick();
        check("freq_lo_n1", 48'(freq[15:0]), 48'h0);
        check("ack_n1", 48'(wr_ack), 48'h0);
        tick();
        check("freq_lo_n2", 48'(freq[15:0]), 48'h0024);
        check("ack_n2", 48'(wr_ack), 48'h1);
        write_reg(2'd0, 3'd1, 8'h00);
        check("freq_hi", 48'(freq[15:0]), 48'h0024);
        check("ack_hi", 48'(wr_ack), 48'h1);
        tick();
        check("ack_drop", 48'(wr_ack), 48'h0);
        check("ack_pair", 48'(ack_cnt - base_ack), 48'd2);

        // Partial-width registers.
        write_reg(2'd1, 3'd3, 8'hF8);
        check("pw_hi_v1", 48'(pw[23:12]), 48'h800);
        write_reg(2'd3, 3'd0, 8'hFF);
        check("fc_lo", 48'(fc), 48'h007);
        write_reg(2'd3, 3'd1, 8'h81);
        check("fc_hi", 48'(fc), 48'h40F);
        write_reg(2'd3, 3'd2, 8'h5C);
        check("res_filt", 48'(res_filt), 48'h5C);
        write_reg(2'd1, 3'd5, 8'hA3);
        check("sus_v1", 48'(sus_rel), 48'h00A300);

        // Gate edges on voice 2.
        tick();
        base_gon  = gon2_cnt;
        base_goff = goff2_cnt;
        write_reg(2'd2, 3'd6, 8'h21);
        check("wav_v2_on", 48'(wav_ctrl[23:16]), 48'h21);
        check("gate_on_early", 48'(gate_on), 48'h0);
        tick();
        check("gate_on_pulse", 48'({gate_on, gate_off}), 48'({3'b100, 3'b000}));
        write_reg(2'd2, 3'd6, 8'h21);
        tick();
        check("gate_rewrite", 48'({gate_on, gate_off}), 48'h0);
        write_reg(2'd2, 3'd6, 8'h20);
        check("wav_v2_off", 48'(wav_ctrl[23:16]), 48'h20);
        tick();
        check("gate_off_pulse", 48'({gate_on, gate_off}), 48'({3'b000, 3'b100}));
        tick();
        check("gate_on_count", 48'(gon2_cnt - base_gon), 48'd1);
        check("gate_off_count", 48'(goff2_cnt - base_goff), 48'd1);

        // Strobe held high for 10 clocks.
        base_ack = ack_cnt;
        wr_bus.voice_sel = 2'd3;
        wr_bus.addr      = 3'd3;
        wr_bus.wr_data   = 8'h1F;
        wr_bus.wr_strobe = 1'b1;
        repeat (10) tick();
        wr_bus.wr_strobe = 1'b0;
        repeat (3) tick();
        check("mode_vol", 48'(mode_vol), 48'h1F);
        check("long_strobe_acks", 48'(ack_cnt - base_ack), 48'd1);

        // Ignored address: ack but no state change.
        write_reg(2'd0, 3'd7, 8'hEE);
        check("ign_ack", 48'(wr_ack), 48'h1);
        check("ign_freq", 48'(freq), 48'h0000_0000_0024);
        check("ign_pw", 48'(pw), 48'h000_800_000);
        check("ign_env_wav", 48'({atk_dcy, wav_ctrl}), 48'({24'h000000, 24'h200000}));
        check("ign_filt", 48'({fc, res_filt, mode_vol}), 48'({11'h40F, 8'h5C, 8'h1F}));
        tick();

        // Disabled write is dropped.
        ena = 1'b0;
        base_ack = ack_cnt;
        write_reg(2'd0, 3'd4, 8'h55);
        check("ena0_atk", 48'(atk_dcy), 48'h0);
        check("ena0_ack", 48'(wr_ack), 48'h0);
        repeat (3) tick();
        check("ena0_no_defer", 48'({atk_dcy, 24'(ack_cnt - base_ack)}), 48'h0);
        ena = 1'b1;
        write_reg(2'd0, 3'd4, 8'h55);
        check("ena1_atk", 48'(atk_dcy), 48'h000055);
        check("ena1_ack", 48'(wr_ack), 48'h1);
        tick();

        // Reset mid-synchronization with strobe high.
        wr_bus.voice_sel = 2'd0;
        wr_bus.addr      = 3'd0;
        wr_bus.wr_data   = 8'h99;
        wr_bus.wr_strobe = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_regs", 48'({freq[23:0], wav_ctrl}), 48'h0);
        check("mid_rst_filt", 48'({fc, res_filt, mode_vol, atk_dcy[7:0]}), 48'h0);
        check("mid_rst_pulses", 48'({gate_on, gate_off, wr_ack}), 48'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base_ack = ack_cnt;
        repeat (5) tick();
        check("held_no_write", 48'({freq, 16'(ack_cnt - base_ack)}), 48'h0);
        wr_bus.wr_strobe = 1'b0;
        tick();
        tick();
        write_reg(2'd0, 3'd0, 8'h99);
        check("post_rst_write", 48'(freq), 48'h0000_0000_0099);
        check("post_rst_ack", 48'(wr_ack), 48'h1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
